memory_stage: RTL and testbench

- Consumer end of the execute stage: latches execute-stage results into the M pipeline register and performs the data-memory load/store.
- Then latches into the W register and produces the writeback result and destination register.
- Also exports M-stage values for the hazard/forwarding unit.
- Sits between instructionExecution and the register file write port.

---
 rtl/memory_stage.sv | 119 +++++++++++
 tb/tb_memory_stage.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// memory_stage: M/W pipeline registers, data memory load/store and writeback mux.
// Optional build macro MISALIGN_TRAP_EN enables misaligned-access trapping.
`default_nettype none

module memory_stage #(
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 64,
  parameter int REG_W     = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              regWriteE,
  input  logic              memToRegE,
  input  logic              memWriteE,
  input  logic [DATA_W-1:0] AluOutE,
  input  logic [DATA_W-1:0] WriteDataE,
  input  logic [REG_W-1:0]  writeRegE,
  input  logic              stallM,
  input  logic              flushM,
  output logic              regWriteM,
  output logic [REG_W-1:0]  writeRegM,
  output logic [DATA_W-1:0] AluOutM,
  output logic              memToRegM,
  output logic              regWriteW,
  output logic [REG_W-1:0]  writeRegW,
  output logic [DATA_W-1:0] ResultW,
  output logic              misalignM
);

  localparam int ADDR_W = $clog2(MEM_DEPTH);

  logic              memWriteM;
  logic [DATA_W-1:0] WriteDataM;
  logic              memToRegW;
  logic [DATA_W-1:0] AluOutW;
  logic [DATA_W-1:0] ReadDataW;

  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic [ADDR_W-1:0] word_addr;
  logic [DATA_W-1:0] ReadDataM;
  logic              misalign;
  logic              mem_we;
  logic              reg_write_ok;

  // Upper address bits are dropped, so addresses wrap modulo MEM_DEPTH*4.
  assign word_addr = AluOutM[ADDR_W+1:2];

`ifdef MISALIGN_TRAP_EN
  assign misalign     = (memWriteM | memToRegM) & (AluOutM[1:0] != 2'b00);
  assign reg_write_ok = regWriteM & ~(memToRegM & misalign);
`else
  assign misalign     = 1'b0;
  assign reg_write_ok = regWriteM;
`endif

  assign misalignM = misalign;

  // A stalled store stays in M, so it writes only on the edge it leaves.
  assign mem_we    = memWriteM & ~stallM & ~misalign;
  assign ReadDataM = mem[word_addr];

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[word_addr] <= WriteDataM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regWriteM  <= 1'b0;
      memToRegM  <= 1'b0;
      memWriteM  <= 1'b0;
      writeRegM  <= '0;
      AluOutM    <= '0;
      WriteDataM <= '0;
    end else if (flushM) begin
      regWriteM  <= 1'b0;
      memToRegM  <= 1'b0;
      memWriteM  <= 1'b0;
      writeRegM  <= '0;
      AluOutM    <= '0;
      WriteDataM <= '0;
    end else if (!stallM) begin
      regWriteM  <= regWriteE & (writeRegE != '0);
      memToRegM  <= memToRegE;
      memWriteM  <= memWriteE;
      writeRegM  <= writeRegE;
      AluOutM    <= AluOutE;
      WriteDataM <= WriteDataE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regWriteW <= 1'b0;
      memToRegW <= 1'b0;
      writeRegW <= '0;
      AluOutW   <= '0;
      ReadDataW <= '0;
    end else if (stallM) begin
      regWriteW <= 1'b0;
      memToRegW <= 1'b0;
      writeRegW <= '0;
      AluOutW   <= '0;
      ReadDataW <= '0;
    end else begin
      regWriteW <= reg_write_ok;
      memToRegW <= memToRegM;
      writeRegW <= writeRegM;
      AluOutW   <= AluOutM;
      ReadDataW <= ReadDataM;
    end
  end

  assign ResultW = memToRegW ? ReadDataW : AluOutW;

endmodule

`default_nettype wire

// File: tb/tb_memory_stage.sv
// Randomized self-checking bench for memory_stage against a transaction-level model.
`default_nettype none

module tb_memory_stage;

  localparam int DATA_W    = 32;
  localparam int MEM_DEPTH = 64;
  localparam int REG_W     = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              regWriteE = 1'b0, memToRegE = 1'b0, memWriteE = 1'b0;
  logic [DATA_W-1:0] AluOutE = '0, WriteDataE = '0;
  logic [REG_W-1:0]  writeRegE = '0;
  logic              stallM = 1'b0, flushM = 1'b0;
  logic              regWriteM, memToRegM, regWriteW, misalignM;
  logic [REG_W-1:0]  writeRegM, writeRegW;
  logic [DATA_W-1:0] AluOutM, ResultW;

  memory_stage #(.DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH), .REG_W(REG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .regWriteE(regWriteE), .memToRegE(memToRegE), .memWriteE(memWriteE),
    .AluOutE(AluOutE), .WriteDataE(WriteDataE), .writeRegE(writeRegE),
    .stallM(stallM), .flushM(flushM),
    .regWriteM(regWriteM), .writeRegM(writeRegM), .AluOutM(AluOutM),
    .memToRegM(memToRegM), .regWriteW(regWriteW), .writeRegW(writeRegW),
    .ResultW(ResultW), .misalignM(misalignM)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rw;
    bit          m2r;
    bit          mw;
    int unsigned wr;
    bit [31:0]   alu;
    bit [31:0]   wd;
  } inst_t;

  inst_t       m_slot;
  bit          w_rw, w_m2r;
  int unsigned w_wr;
  bit [31:0]   w_alu, w_rd;
  bit [31:0]   ref_mem [MEM_DEPTH];

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
  endtask

  function automatic bit is_misaligned(inst_t i);
`ifdef MISALIGN_TRAP_EN
    return (i.mw || i.m2r) && (i.alu % 4 != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int unsigned word_of(bit [31:0] a);
    return (a / 4) % MEM_DEPTH;
  endfunction

  task automatic clear_model();
    m_slot = '{default: 0};
    w_rw = 0; w_m2r = 0; w_wr = 0; w_alu = 0; w_rd = 0;
  endtask

  task automatic check_all();
    check("regWriteM", 32'(regWriteM), 32'(m_slot.rw));
    check("writeRegM", 32'(writeRegM), m_slot.wr);
    check("AluOutM",   AluOutM,        m_slot.alu);
    check("memToRegM", 32'(memToRegM), 32'(m_slot.m2r));
    check("misalignM", 32'(misalignM), 32'(is_misaligned(m_slot)));
    check("regWriteW", 32'(regWriteW), 32'(w_rw));
    check("writeRegW", 32'(writeRegW), w_wr);
    check("ResultW",   ResultW,        w_m2r ? w_rd : w_alu);
  endtask

  task automatic drive(input bit rw, input bit m2r, input bit mw, input bit [31:0] alu,
                       input bit [31:0] wd, input int unsigned wr, input bit st, input bit fl);
    regWriteE = rw; memToRegE = m2r; memWriteE = mw;
    AluOutE = alu; WriteDataE = wd; writeRegE = REG_W'(wr);
    stallM = st; flushM = fl;
  endtask

  // One clock: advance the model by the pipeline rules, then compare.
  task automatic tick();
    inst_t e;
    bit st, fl, mis;
    e.rw  = regWriteE && (writeRegE != 0);
    e.m2r = memToRegE; e.mw = memWriteE; e.wr = writeRegE;
    e.alu = AluOutE;   e.wd = WriteDataE;
    st = stallM; fl = flushM;
    @(posedge clk);
    mis = is_misaligned(m_slot);
    if (st) begin
      w_rw = 0; w_m2r = 0; w_wr = 0; w_alu = 0; w_rd = 0;
    end else begin
      w_rw  = m_slot.rw && !(mis && m_slot.m2r);
      w_m2r = m_slot.m2r; w_wr = m_slot.wr; w_alu = m_slot.alu;
      w_rd  = ref_mem[word_of(m_slot.alu)];
    end
    if (m_slot.mw && !st && !mis) ref_mem[word_of(m_slot.alu)] = m_slot.wd;
    if (fl) m_slot = '{default: 0};
    else if (!st) m_slot = e;
    #1;
    check_all();
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    clear_model();
    #12;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Fill every memory word so later loads have defined contents.
    for (int i = 0; i < MEM_DEPTH; i++) begin
      drive(0, 0, 1, 32'(i * 4), $urandom, 0, 0, 0);
      tick();
    end

    // Store then back-to-back load of the same word.
    drive(0, 0, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0); tick();
    drive(1, 1, 0, 32'h10, 0, 3, 0, 0);            tick();
    idle();                                        tick();
    check("t1_result", ResultW, 32'hDEADBEEF);
    check("t1_wreg", 32'(writeRegW), 32'd3);
    check("t1_rw", 32'(regWriteW), 32'd1);

    drive(1, 0, 0, 32'd22, 0, 3, 0, 0); tick();
    check("t2_aluM", AluOutM, 32'd22);
    check("t2_rwM", 32'(regWriteM), 32'd1);
    idle(); tick();
    check("t2_result", ResultW, 32'd22);

    drive(1, 0, 0, 32'd7, 0, 0, 0, 0); tick();
    check("t3_rwM", 32'(regWriteM), 32'd0);
    idle(); tick();
    check("t3_rwW", 32'(regWriteW), 32'd0);

    // Stalled store, then a second store to the same word, then load it.
    drive(0, 0, 1, 32'h20, 32'hAAAA0001, 0, 0, 0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 32'h20, 32'hBBBB0002, 0, 1, 0); tick();
      check("t4_hold", AluOutM, 32'h20);
      check("t4_rwW", 32'(regWriteW), 32'd0);
    end
    drive(0, 0, 1, 32'h20, 32'hBBBB0002, 0, 0, 0); tick();
    drive(1, 1, 0, 32'h20, 0, 9, 0, 0);            tick();
    idle(); tick();
    check("t4_result", ResultW, 32'hBBBB0002);
    drive(1, 0, 0, 32'h44, 0, 6, 0, 0); tick();
    drive(1, 0, 0, 32'h48, 0, 7, 1, 1); tick();
    check("t4_flush_rw", 32'(regWriteM), 32'd0);
    check("t4_flush_alu", AluOutM, 32'd0);

    // Address wrap modulo MEM_DEPTH*4.
    drive(0, 0, 1, 32'h100, 32'h55, 0, 0, 0); tick();
    drive(1, 1, 0, 32'h0, 0, 4, 0, 0);        tick();
    idle(); tick();
    check("t5_wrap", ResultW, 32'h55);

    // Misaligned store to word 4.
    drive(0, 0, 1, 32'h12, 32'h77, 0, 0, 0); tick();
`ifdef MISALIGN_TRAP_EN
    check("t6_mis", 32'(misalignM), 32'd1);
`else
    check("t6_mis", 32'(misalignM), 32'd0);
`endif
    drive(1, 1, 0, 32'h10, 0, 5, 0, 0); tick();
    idle(); tick();
`ifdef MISALIGN_TRAP_EN
    check("t6_word", ResultW, 32'hDEADBEEF);
`else
    check("t6_word", ResultW, 32'h77);
`endif

    // Reset asserted while a load sits in W.
    drive(1, 1, 0, 32'h10, 0, 5, 0, 0); tick();
    idle(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_rwW", 32'(regWriteW), 32'd0);
    check("rst_result", ResultW, 32'd0);
    clear_model();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      int unsigned kind;
      bit [31:0] addr;
      kind = $urandom_range(0, 2);
      addr = $urandom_range(0, 1023) & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) addr = addr | 32'($urandom_range(1, 3));
      case (kind)
        0: drive(1, 0, 0, $urandom, 0, $urandom_range(0, 31), 0, 0);
        1: drive(1, 1, 0, addr, 0, $urandom_range(0, 31), 0, 0);
        default: drive(0, 0, 1, addr, $urandom, 0, 0, 0);
      endcase
      stallM = ($urandom_range(0, 7) == 0);
      flushM = ($urandom_range(0, 9) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
